phys_reg_alloc_ctrl: RTL and testbench
======================================

Name: phys_reg_alloc_ctrl

Overview:
- Allocation controller between the N-wide dispatch stage and the physical-register freelist.
- Tracks the number of free physical registers and grants dispatch lanes in program order (an in-order prefix).
- Drives the freelist allocate enables and steers the compacted freelist outputs back to the requesting lanes.
- Holds off allocation during a post-reset seeding window and flags count/freelist disagreement.

Parameters:
- N, `N, dispatch/retire width.
- PR_COUNT, `PHYS_REG_SZ_R10K, number of physical registers.
- ARCH_COUNT, 32, architectural registers; initial free count is PR_COUNT-ARCH_COUNT.
- INIT_CYCLES, 2, cycles after reset during which no grants are issued (freelist seeding).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- DispReq  in  N  lane i holds a valid instruction (lane 0 oldest).
- DispNeedDest  in  N  lane i writes a non-zero destination and needs a tag.
- DispGnt  out  N  lane i may dispatch this cycle.
- DispDestTag  out  N x PHYS_TAG  tag for lane i; valid when DispGnt[i] & DispNeedDest[i].
- FlAllocEN  out  N  to freelist allocate enables; always a low-order contiguous mask.
- FlFreeReg  in  N x PHYS_TAG  freelist outputs, compacted, oldest first.
- FlFreeRegValid  in  N  freelist output valids.
- RetireEN  in  N  retire returns this cycle; also driven to the freelist.
- FreeCount  out  $clog2(PR_COUNT+1)  registered free-register count.
- StallCount  out  32  cycles with any DispReq lane denied while in RUN.
- Err  out  1  sticky; count/freelist mismatch or counter overflow.

Behaviour:
- Reset (reset=1 at a rising edge):
  - FreeCount=PR_COUNT-ARCH_COUNT, StallCount=0, Err=0.
  - FSM enters INIT with its cycle counter at 0.
  - Reset mid-operation discards all pending state identically.
- FSM:
  - INIT: DispGnt=0 and FlAllocEN=0. Counter increments each cycle; after INIT_CYCLES cycles in INIT, go to RUN.
  - RUN: normal operation. Leaves RUN only on reset.
- Grant rule in RUN (combinational):
  - Walk lanes 0..N-1 and keep a running need count k (number of lanes with DispReq&DispNeedDest so far).
  - Lane i is granted iff DispReq[i], all older requesting lanes are granted, and (if DispNeedDest[i]) k < FreeCount and FlFreeRegValid[k]=1.
  - The first denied requesting lane blocks all younger lanes.
  - A non-requesting lane never blocks younger lanes.
  - A lane with DispNeedDest=0 needs no tag and is granted whenever all older requesting lanes are granted.
- Tag steering:
  - Granted lane i with a destination gets DispDestTag[i]=FlFreeReg[k], where k = number of granted dest-needing lanes older than i.
  - DispDestTag is don't-care for other lanes; drive it to 0.
- FlAllocEN: bits [A-1:0] set, where A = number of granted dest-needing lanes.
- Update each cycle in RUN:
  - FreeCount_next = FreeCount - A + popcount(RetireEN).
  - Registers retired this cycle are not usable for grants until the next cycle; there is no bypass.
- Same-cycle alloc and retire are both applied. Full retire of N with zero allocs is legal.
- RetireEN counts in INIT too: FreeCount_next = FreeCount + popcount(RetireEN).
- Err is set (sticky until reset) when any of these holds:
  - FreeCount_next would exceed PR_COUNT-1.
  - A would underflow FreeCount.
  - In RUN, FlFreeRegValid[j]=0 for some j < min(N, FreeCount).
  - On error, FreeCount saturates at its bound.
- StallCount increments (wrapping at 2^32) in each RUN cycle where some lane has DispReq=1 and DispGnt=0.
- Latency: grants and tags are 0-cycle combinational from inputs and registered state. Count updates take effect 1 cycle later.

Test Plan (N=3, PR_COUNT=64, ARCH_COUNT=32, INIT_CYCLES=2):
1. Reset, then DispReq=111 and DispNeedDest=111 every cycle, freelist supplying valid tags -> DispGnt=000 for 2 cycles, then 111. FreeCount reads 32, 29, 26, ...
2. FreeCount=2, DispReq=111, DispNeedDest=111 -> DispGnt=011, FlAllocEN=011, FreeCount_next=0, StallCount +1.
3. FreeCount=1, DispReq=111, DispNeedDest=010, FlFreeReg={50,49,48} -> DispGnt=111, DispDestTag[1]=48, FlAllocEN=001.
4. FreeCount=0, RetireEN=111, DispReq=001 with need -> DispGnt=000 this cycle. Next cycle FreeCount=3 and DispGnt=001.
5. DispReq=101 (lane 1 idle), both lanes need, FreeCount=5 -> DispGnt=101, DispDestTag[0]=FlFreeReg[0], DispDestTag[2]=FlFreeReg[1].
6. In RUN with FreeCount=10, force FlFreeRegValid=001 -> Err=1 next cycle and stays 1 until reset; reset asserted mid-stream returns FreeCount=32 and FSM to INIT.

Source files
------------

// File: rtl/phys_reg_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phys_reg_alloc_ctrl
// Brief    : In-order dispatch grant and physical-register tag steering
//            against the freelist, with free-count tracking and error flag.
// Revision : 1.0 - initial release
// ============================================================================
module phys_reg_alloc_ctrl #(
    parameter int N           = 3,
    parameter int PR_COUNT    = 64,
    parameter int ARCH_COUNT  = 32,
    parameter int INIT_CYCLES = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [N-1:0]                          DispReq,
    input  logic [N-1:0]                          DispNeedDest,
    output logic [N-1:0]                          DispGnt,
    output logic [N*$clog2(PR_COUNT)-1:0]         DispDestTag,
    output logic [N-1:0]                          FlAllocEN,
    input  logic [N*$clog2(PR_COUNT)-1:0]         FlFreeReg,
    input  logic [N-1:0]                          FlFreeRegValid,
    input  logic [N-1:0]                          RetireEN,
    output logic [$clog2(PR_COUNT+1)-1:0]         FreeCount,
    output logic [31:0]                           StallCount,
    output logic                                  Err
);

    localparam int c_TAG = $clog2(PR_COUNT);
    localparam int c_CW  = $clog2(PR_COUNT+1);
    localparam int c_KW  = $clog2(N+1);
    localparam int c_ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_ICW-1:0]     r_init_cnt;
    logic [c_CW-1:0]      r_free_count;
    logic [31:0]          r_stall_count;
    logic                 r_err;

    logic [N-1:0]         w_gnt;
    logic [N*c_TAG-1:0]   w_tag;
    logic [c_KW-1:0]      w_alloc_cnt;
    logic [c_KW-1:0]      w_ret_cnt;
    logic [N-1:0]         w_alloc_en;
    logic                 w_under;
    logic                 w_over;
    logic                 w_valid_err;
    logic [c_CW:0]        w_next_raw;
    logic [c_CW-1:0]      w_next_count;
    logic                 w_stall;

    // Grant walk: k counts granted destination lanes; the first denied requester blocks the rest.
    always_comb begin
        logic          blocked;
        logic [c_KW-1:0] k;
        int            idx;
        w_gnt   = '0;
        w_tag   = '0;
        blocked = 1'b0;
        k       = '0;
        idx     = 0;
        if (r_state == S_RUN) begin
            for (int i = 0; i < N; i++) begin
                if (DispReq[i] && !blocked) begin
                    if (DispNeedDest[i]) begin
                        idx = int'(k);
                        if (({{(c_CW-c_KW){1'b0}}, k} < r_free_count) && FlFreeRegValid[idx]) begin
                            w_gnt[i]                = 1'b1;
                            w_tag[i*c_TAG +: c_TAG] = FlFreeReg[idx*c_TAG +: c_TAG];
                            k                       = k + 1'b1;
                        end else begin
                            blocked = 1'b1;
                        end
                    end else begin
                        w_gnt[i] = 1'b1;
                    end
                end
            end
        end
        w_alloc_cnt = k;
    end

    always_comb begin
        w_ret_cnt  = '0;
        w_alloc_en = '0;
        for (int i = 0; i < N; i++) begin
            w_ret_cnt = w_ret_cnt + {{(c_KW-1){1'b0}}, RetireEN[i]};
            if (c_KW'(i) < w_alloc_cnt) begin
                w_alloc_en[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_valid_err = 1'b0;
        if (r_state == S_RUN) begin
            for (int j = 0; j < N; j++) begin
                if ((c_CW'(j) < r_free_count) && !FlFreeRegValid[j]) begin
                    w_valid_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_under    = ({{(c_CW-c_KW){1'b0}}, w_alloc_cnt} > r_free_count);
        w_next_raw = {1'b0, r_free_count} + {{(c_CW+1-c_KW){1'b0}}, w_ret_cnt}
                   - {{(c_CW+1-c_KW){1'b0}}, w_alloc_cnt};
        w_over     = !w_under && (w_next_raw > (c_CW+1)'(PR_COUNT-1));
        if (w_under) begin
            w_next_count = '0;
        end else if (w_over) begin
            w_next_count = c_CW'(PR_COUNT-1);
        end else begin
            w_next_count = w_next_raw[c_CW-1:0];
        end
        w_stall = (r_state == S_RUN) && |(DispReq & ~w_gnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_INIT;
            r_init_cnt    <= '0;
            r_free_count  <= c_CW'(PR_COUNT-ARCH_COUNT);
            r_stall_count <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == c_ICW'(INIT_CYCLES-1)) begin
                        r_state <= S_RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
            r_free_count <= w_next_count;
            if (w_stall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_under || w_over || w_valid_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign DispGnt     = w_gnt;
    assign DispDestTag = w_tag;
    assign FlAllocEN   = w_alloc_en;
    assign FreeCount   = r_free_count;
    assign StallCount  = r_stall_count;
    assign Err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_phys_reg_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_phys_reg_alloc_ctrl
// Brief    : Directed self-checking bench for phys_reg_alloc_ctrl (N=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_phys_reg_alloc_ctrl;

    localparam int c_N   = 3;
    localparam int c_TAG = 6;

    logic                 clk;
    logic                 rst;
    logic [c_N-1:0]       r_req;
    logic [c_N-1:0]       r_need;
    logic [c_N-1:0]       w_gnt;
    logic [c_N*c_TAG-1:0] w_tag;
    logic [c_N-1:0]       w_alloc;
    logic [c_N*c_TAG-1:0] r_fl_reg;
    logic [c_N-1:0]       r_fl_valid;
    logic [c_N-1:0]       r_retire;
    logic [6:0]           w_free_count;
    logic [31:0]          w_stall_count;
    logic                 w_err;

    int r_compared;
    int r_mismatched;

    phys_reg_alloc_ctrl #(
        .N(3), .PR_COUNT(64), .ARCH_COUNT(32), .INIT_CYCLES(2)
    ) u_dut (
        .clock          (clk),
        .reset          (rst),
        .DispReq        (r_req),
        .DispNeedDest   (r_need),
        .DispGnt        (w_gnt),
        .DispDestTag    (w_tag),
        .FlAllocEN      (w_alloc),
        .FlFreeReg      (r_fl_reg),
        .FlFreeRegValid (r_fl_valid),
        .RetireEN       (r_retire),
        .FreeCount      (w_free_count),
        .StallCount     (w_stall_count),
        .Err            (w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        r_compared++;
        if (got !== exp) begin
            r_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        r_compared   = 0;
        r_mismatched = 0;
        rst        = 1'b1;
        r_req      = '0;
        r_need     = '0;
        r_retire   = '0;
        r_fl_valid = 3'b111;
        r_fl_reg   = {6'd12, 6'd11, 6'd10};
        tick();
        tick();
        rst = 1'b0;

        // Reset state and INIT hold-off
        chk("rst_free", w_free_count, 32);
        chk("rst_err", w_err, 0);
        chk("rst_stall", w_stall_count, 0);
        r_req  = 3'b111;
        r_need = 3'b111;
        settle();
        chk("init0_gnt", w_gnt, 3'b000);
        chk("init0_alloc", w_alloc, 3'b000);
        tick();
        chk("init1_gnt", w_gnt, 3'b000);
        chk("init1_free", w_free_count, 32);
        tick();
        chk("run_gnt", w_gnt, 3'b111);
        chk("run_alloc", w_alloc, 3'b111);
        chk("run_tag1", w_tag[c_TAG +: c_TAG], 11);
        chk("run_tag2", w_tag[2*c_TAG +: c_TAG], 12);
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("drain_free", w_free_count, 64'(32 - 3*c));
        end

        // FreeCount=2: only two lanes fit
        settle();
        chk("fc2_gnt", w_gnt, 3'b011);
        chk("fc2_alloc", w_alloc, 3'b011);
        tick();
        chk("fc2_next", w_free_count, 0);
        chk("fc2_stall", w_stall_count, 1);

        r_req    = '0;
        r_retire = 3'b001;
        tick();
        r_retire = '0;
        chk("fc1_free", w_free_count, 1);

        // FreeCount=1 with only lane 1 needing a tag
        r_req    = 3'b111;
        r_need   = 3'b010;
        r_fl_reg = {6'd50, 6'd49, 6'd48};
        settle();
        chk("fc1_gnt", w_gnt, 3'b111);
        chk("fc1_tag1", w_tag[c_TAG +: c_TAG], 48);
        chk("fc1_tag0", w_tag[0 +: c_TAG], 0);
        chk("fc1_alloc", w_alloc, 3'b001);
        tick();
        chk("fc1_next", w_free_count, 0);

        // Retired registers are not usable until the next cycle
        r_fl_reg = {6'd12, 6'd11, 6'd10};
        r_retire = 3'b111;
        r_req    = 3'b001;
        r_need   = 3'b001;
        settle();
        chk("nobypass_gnt", w_gnt, 3'b000);
        tick();
        r_retire = '0;
        settle();
        chk("ret_free", w_free_count, 3);
        chk("ret_gnt", w_gnt, 3'b001);
        chk("ret_stall", w_stall_count, 2);
        tick();
        chk("ret_next", w_free_count, 2);

        // Idle lane 1 does not block lane 2
        r_req    = '0;
        r_retire = 3'b111;
        tick();
        r_retire = '0;
        chk("fc5_free", w_free_count, 5);
        r_req  = 3'b101;
        r_need = 3'b101;
        settle();
        chk("gap_gnt", w_gnt, 3'b101);
        chk("gap_tag0", w_tag[0 +: c_TAG], 10);
        chk("gap_tag2", w_tag[2*c_TAG +: c_TAG], 11);
        chk("gap_alloc", w_alloc, 3'b011);
        tick();
        chk("gap_next", w_free_count, 3);

        // Freelist valid disagreement sets a sticky error
        r_req    = '0;
        r_retire = 3'b111;
        tick();
        tick();
        r_retire = 3'b001;
        tick();
        r_retire = '0;
        chk("fc10_free", w_free_count, 10);
        chk("fc10_err", w_err, 0);
        r_fl_valid = 3'b001;
        tick();
        chk("valid_err", w_err, 1);
        r_fl_valid = 3'b111;
        tick();
        tick();
        chk("err_sticky", w_err, 1);
        chk("err_stall", w_stall_count, 2);

        // Mid-stream reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_free", w_free_count, 32);
        chk("rst2_err", w_err, 0);
        chk("rst2_stall", w_stall_count, 0);
        r_req  = 3'b111;
        r_need = 3'b111;
        settle();
        chk("rst2_gnt", w_gnt, 3'b000);

        // Retire overflow past PR_COUNT-1 saturates and flags
        r_req    = '0;
        r_retire = 3'b111;
        for (int c = 1; c <= 10; c++) begin
            tick();
        end
        chk("ovf_pre_free", w_free_count, 62);
        chk("ovf_pre_err", w_err, 0);
        tick();
        r_retire = '0;
        chk("ovf_free", w_free_count, 63);
        chk("ovf_err", w_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_compared, r_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
